// File: rtl/instruction_decode_fsm.sv
// Fetch/decode sequencer: ROM fetch, field split, dual source read,
// hazard-aware issue to the execution FSM and branch redirect.
module instruction_decode_fsm #(
  parameter int ROM_ADDR_W  = 16,
  parameter int INST_W      = 64,
  parameter int OP_W        = 16,
  parameter int DATA_ADDR_W = 16,
  parameter int DATA_ROW_W  = 96,
  parameter logic [OP_W-1:0] RETURN_OP = 16'h0001
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iEnable,
  input  logic [ROM_ADDR_W-1:0]  iInitialIp,
  output logic [ROM_ADDR_W-1:0]  oInstructionAddress,
  input  logic [INST_W-1:0]      iInstruction,
  output logic [DATA_ADDR_W-1:0] oRAMReadAddress0,
  output logic [DATA_ADDR_W-1:0] oRAMReadAddress1,
  input  logic [DATA_ROW_W-1:0]  iRAMData0,
  input  logic [DATA_ROW_W-1:0]  iRAMData1,
  input  logic                   iExeBusy,
  input  logic [DATA_ADDR_W-1:0] iLastDestination,
  input  logic                   iBranchTaken,
  input  logic                   iBranchNotTaken,
  input  logic [ROM_ADDR_W-1:0]  iJumpIp,
  output logic                   oDecodeDone,
  output logic [OP_W-1:0]        oOperation,
  output logic [DATA_ADDR_W-1:0] oDestination,
  output logic [DATA_ROW_W-1:0]  oSource0,
  output logic [DATA_ROW_W-1:0]  oSource1,
  output logic [ROM_ADDR_W-1:0]  oCurrentIp,
  output logic                   oBusy,
  output logic                   oProgramDone
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH_INST,
    READ_DATA,
    ISSUE,
    WAIT_BRANCH
  } state_t;

  localparam logic [ROM_ADDR_W-1:0] IP_ONE = 1;

  state_t                 state;
  logic [ROM_ADDR_W-1:0]  ip;
  logic [DATA_ADDR_W-1:0] src0;
  logic [DATA_ADDR_W-1:0] src1;
  logic                   pending;

  logic [OP_W-1:0]        f_op;
  logic [DATA_ADDR_W-1:0] f_dest;
  logic [DATA_ADDR_W-1:0] f_src1;
  logic [DATA_ADDR_W-1:0] f_src0;
  logic                   hazard;
  logic                   issue_ok;
  logic                   is_branch;
  logic                   is_return;

  assign f_op   = iInstruction[INST_W-1 -: OP_W];
  assign f_dest = iInstruction[2*DATA_ADDR_W +: DATA_ADDR_W];
  assign f_src1 = iInstruction[DATA_ADDR_W +: DATA_ADDR_W];
  assign f_src0 = iInstruction[0 +: DATA_ADDR_W];

  assign hazard = iExeBusy &&
    (src0 == iLastDestination || src1 == iLastDestination);
  assign is_branch = oOperation[OP_W-1];
  assign is_return = oOperation == RETURN_OP;
  assign issue_ok  = state == ISSUE && !iExeBusy && !pending;

  // Strobes follow ISSUE and the live busy input, so they never
  // coincide with iExeBusy high.
  assign oDecodeDone  = issue_ok;
  assign oProgramDone = issue_ok && !is_branch && is_return;
  assign oBusy        = state != IDLE;

  assign oInstructionAddress = ip;
  // Sync RAM must see the source rows while ROM data is on the bus.
  assign oRAMReadAddress0 = (state == LATCH_INST) ? f_src0 : src0;
  assign oRAMReadAddress1 = (state == LATCH_INST) ? f_src1 : src1;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      ip           <= '0;
      src0         <= '0;
      src1         <= '0;
      pending      <= 1'b0;
      oOperation   <= '0;
      oDestination <= '0;
      oSource0     <= '0;
      oSource1     <= '0;
      oCurrentIp   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (iEnable) begin
            ip    <= iInitialIp;
            state <= FETCH;
          end
        end
        FETCH: state <= LATCH_INST;
        LATCH_INST: begin
          oOperation   <= f_op;
          oDestination <= f_dest;
          src0         <= f_src0;
          src1         <= f_src1;
          oCurrentIp   <= ip;
          state        <= READ_DATA;
        end
        READ_DATA: begin
          oSource0 <= iRAMData0;
          oSource1 <= iRAMData1;
          state    <= ISSUE;
        end
        ISSUE: begin
          if (iExeBusy) begin
            if (hazard) pending <= 1'b1;
          end else if (pending) begin
            // re-read so the write-back row is captured
            pending <= 1'b0;
            state   <= READ_DATA;
          end else if (is_branch) begin
            state <= WAIT_BRANCH;
          end else if (is_return) begin
            state <= IDLE;
          end else begin
            ip    <= ip + IP_ONE;
            state <= FETCH;
          end
        end
        WAIT_BRANCH: begin
          if (iBranchTaken) begin
            ip    <= iJumpIp;
            state <= FETCH;
          end else if (iBranchNotTaken) begin
            ip    <= ip + IP_ONE;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_decode_fsm.sv
// Directed bench: ROM/RAM models, vector table for field split,
// hand sequences for stall, hazard, branch, wrap and reset.
module tb_instruction_decode_fsm;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        iEnable = 1'b0;
  logic [15:0] iInitialIp = '0;
  logic [15:0] oInstructionAddress;
  logic [63:0] iInstruction = '0;
  logic [15:0] oRAMReadAddress0;
  logic [15:0] oRAMReadAddress1;
  logic [95:0] iRAMData0 = '0;
  logic [95:0] iRAMData1 = '0;
  logic        iExeBusy = 1'b0;
  logic [15:0] iLastDestination = 16'hFFFF;
  logic        iBranchTaken = 1'b0;
  logic        iBranchNotTaken = 1'b0;
  logic [15:0] iJumpIp = '0;
  logic        oDecodeDone;
  logic [15:0] oOperation;
  logic [15:0] oDestination;
  logic [95:0] oSource0;
  logic [95:0] oSource1;
  logic [15:0] oCurrentIp;
  logic        oBusy;
  logic        oProgramDone;

  instruction_decode_fsm dut (
    .Clock(Clock),
    .Reset(Reset),
    .iEnable(iEnable),
    .iInitialIp(iInitialIp),
    .oInstructionAddress(oInstructionAddress),
    .iInstruction(iInstruction),
    .oRAMReadAddress0(oRAMReadAddress0),
    .oRAMReadAddress1(oRAMReadAddress1),
    .iRAMData0(iRAMData0),
    .iRAMData1(iRAMData1),
    .iExeBusy(iExeBusy),
    .iLastDestination(iLastDestination),
    .iBranchTaken(iBranchTaken),
    .iBranchNotTaken(iBranchNotTaken),
    .iJumpIp(iJumpIp),
    .oDecodeDone(oDecodeDone),
    .oOperation(oOperation),
    .oDestination(oDestination),
    .oSource0(oSource0),
    .oSource1(oSource1),
    .oCurrentIp(oCurrentIp),
    .oBusy(oBusy),
    .oProgramDone(oProgramDone)
  );

  always #5 Clock = ~Clock;

  logic [63:0] rom [0:65535];
  logic [95:0] ram [0:255];

  always @(posedge Clock) begin
    iInstruction <= rom[oInstructionAddress];
    iRAMData0    <= ram[oRAMReadAddress0[7:0]];
    iRAMData1    <= ram[oRAMReadAddress1[7:0]];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic start(input logic [15:0] ip);
    tick();
    iInitialIp = ip;
    iEnable = 1'b1;
    cyc = 0;
    tick();
    iEnable = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output bit found);
    found = 1'b0;
    for (int k = 0; k < maxc && !found; k++) begin
      @(negedge Clock);
      if (oDecodeDone) found = 1'b1;
      else tick();
    end
  endtask

  task automatic observe(input int lo_cyc, input int end_cyc,
                         input bit wr, input logic [95:0] wdat,
                         output int first, output int n,
                         output int bad);
    first = -1;
    n = 0;
    bad = 0;
    while (cyc <= end_cyc) begin
      if (cyc == lo_cyc) begin
        iExeBusy = 1'b0;
        if (wr) ram[8'h22] = wdat;
      end
      @(negedge Clock);
      if (oDecodeDone) begin
        n++;
        if (first < 0) first = cyc;
        if (iExeBusy) bad++;
      end
      tick();
    end
  endtask

  typedef struct {
    logic [15:0] ip;
    logic [63:0] inst;
    logic [95:0] d0;
    logic [95:0] d1;
    logic [15:0] op;
    logic [15:0] dest;
    bit          pdone;
  } vec_t;

  typedef struct {
    bit          tk;
    bit          nt;
    logic [15:0] jump;
    logic [15:0] exp_addr;
  } br_t;

  localparam logic [95:0] DA = 96'hAAAA_0001_BBBB_0002_CCCC_0003;
  localparam logic [95:0] DB = 96'h1111_2222_3333_4444_5555_6666;
  localparam logic [95:0] DC = 96'hC0DE_C0DE_0000_0007_FEED_BEEF;

  vec_t vecs [3];
  br_t  brs  [3];

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit   f;
    int   first;
    int   n;
    int   bad;
    logic [15:0] s0;
    logic [15:0] s1;

    vecs[0] = '{16'h0000, 64'h0002_0010_0021_0022, DA, DB,
                16'h0002, 16'h0010, 1'b0};
    vecs[1] = '{16'h1234, 64'h7FFF_ABCD_0003_00F0,
                96'h1, {96{1'b1}}, 16'h7FFF, 16'hABCD, 1'b0};
    vecs[2] = '{16'h0009, 64'h0001_0055_0044_0033, DB, DC,
                16'h0001, 16'h0055, 1'b1};
    brs[0] = '{1'b1, 1'b0, 16'h0040, 16'h0040};
    brs[1] = '{1'b0, 1'b1, 16'h0040, 16'h0004};
    brs[2] = '{1'b1, 1'b1, 16'h0077, 16'h0077};

    for (int i = 0; i < 65536; i++) rom[i] = '0;
    for (int i = 0; i < 256; i++) ram[i] = '0;
    rom[16'h0005] = 64'h0010_0001_0002_0003;
    rom[16'h0006] = 64'h0011_0004_0005_0006;
    rom[16'h0007] = 64'h0001_0000_0000_0000;
    rom[16'h0020] = 64'h0004_0030_0031_0032;
    rom[16'h0030] = 64'h0005_0040_0021_0022;
    rom[16'h0003] = 64'h8001_0000_0000_0000;
    rom[16'hFFFF] = 64'h0002_0001_0002_0003;

    // reset state
    tick();
    tick();
    @(negedge Clock);
    check("rst_busy", oBusy, 0);
    check("rst_done", oDecodeDone, 0);
    check("rst_pdone", oProgramDone, 0);
    check("rst_iaddr", oInstructionAddress, 0);
    check("rst_raddr", {oRAMReadAddress1, oRAMReadAddress0}, 0);
    check("rst_pkt", {oOperation, oDestination, oCurrentIp}, 0);
    check("rst_src", {oSource1, oSource0}, 0);
    Reset = 1'b0;

    // field split table
    foreach (vecs[i]) begin
      s0 = vecs[i].inst[15:0];
      s1 = vecs[i].inst[31:16];
      rom[vecs[i].ip] = vecs[i].inst;
      ram[s0[7:0]] = vecs[i].d0;
      ram[s1[7:0]] = vecs[i].d1;
      start(vecs[i].ip);
      wait_done(12, f);
      check("vec_seen", f, 1);
      check("vec_latency", cyc, 4);
      check("vec_op", oOperation, vecs[i].op);
      check("vec_dest", oDestination, vecs[i].dest);
      check("vec_src0", oSource0, vecs[i].d0);
      check("vec_src1", oSource1, vecs[i].d1);
      check("vec_curip", oCurrentIp, vecs[i].ip);
      check("vec_pdone", oProgramDone, vecs[i].pdone);
      do_reset();
    end

    // straight line ADD/SUB/RETURN
    start(16'h0005);
    for (int i = 0; i < 3; i++) begin
      wait_done(8, f);
      check("line_seen", f, 1);
      check("line_cycle", cyc, 4 * (i + 1));
      check("line_curip", oCurrentIp, 16'h0005 + 16'(i));
      check("line_pdone", oProgramDone, (i == 2) ? 1 : 0);
      tick();
    end
    @(negedge Clock);
    check("line_idle_busy", oBusy, 0);

    // busy stall, no address match
    iLastDestination = 16'h0099;
    iExeBusy = 1'b1;
    start(16'h0020);
    observe(10, 12, 1'b0, '0, first, n, bad);
    check("stall_first", first, 10);
    check("stall_count", n, 1);
    check("stall_busy_strobe", bad, 0);
    do_reset();

    // RAW hazard on src0 with write-back as busy falls
    ram[8'h22] = DA;
    iLastDestination = 16'h0022;
    iExeBusy = 1'b1;
    start(16'h0030);
    observe(8, 12, 1'b1, DC, first, n, bad);
    check("raw_first", first, 10);
    check("raw_count", n, 1);
    check("raw_busy_strobe", bad, 0);
    check("raw_src0", oSource0, DC);
    check("raw_src1", oSource1, DB);
    iLastDestination = 16'hFFFF;
    do_reset();

    // branch resolution
    foreach (brs[i]) begin
      start(16'h0003);
      wait_done(8, f);
      check("br_latency", cyc, 4);
      tick();
      tick();
      @(negedge Clock);
      check("br_hold_busy", oBusy, 1);
      check("br_hold_addr", oInstructionAddress, 16'h0003);
      iBranchTaken = brs[i].tk;
      iBranchNotTaken = brs[i].nt;
      iJumpIp = brs[i].jump;
      tick();
      iBranchTaken = 1'b0;
      iBranchNotTaken = 1'b0;
      @(negedge Clock);
      check("br_next_addr", oInstructionAddress, brs[i].exp_addr);
      do_reset();
    end

    // IP wrap
    start(16'hFFFF);
    wait_done(8, f);
    check("wrap_latency", cyc, 4);
    tick();
    @(negedge Clock);
    check("wrap_addr", oInstructionAddress, 16'h0000);
    check("wrap_busy", oBusy, 1);
    do_reset();

    // async reset in READ_DATA
    start(16'h0005);
    tick();
    tick();
    Reset = 1'b1;
    #1;
    check("arst_busy", oBusy, 0);
    check("arst_done", oDecodeDone, 0);
    check("arst_iaddr", oInstructionAddress, 0);
    check("arst_raddr", {oRAMReadAddress1, oRAMReadAddress0}, 0);
    check("arst_pkt", {oOperation, oDestination, oCurrentIp}, 0);
    check("arst_src", {oSource1, oSource0}, 0);
    tick();
    tick();
    Reset = 1'b0;
    observe(-1, 10, 1'b0, '0, first, n, bad);
    check("arst_no_strobe", n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
